// File: rtl/ecc_decoder.sv
// ecc_decoder: sequential SEC-DED decoder for sixteen [8,4,4] nibble codewords.
// Recovers a 64-bit word, counts corrected codewords and flags the uncorrectable ones.
module ecc_decoder #(
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] Encoded_MEM_flat,
  output logic         busy,
  output logic         valid_out,
  output logic [63:0]  data_out,
  output logic [4:0]   corrected_count,
  output logic         uncorrectable,
  output logic [15:0]  err_map
);

  typedef enum logic [1:0] {IDLE, DECODE, DONE} state_t;

  typedef struct packed {
    logic [3:0] nib;
    logic       corr;
    logic       unc;
  } cw_result_t;

  localparam logic [4:0] LAST_INDEX = 5'd16;
  localparam logic [4:0] STEP       = 5'(LANES);

  state_t        state;
  state_t        state_next;
  logic [127:0]  captured;
  logic [4:0]    index;
  logic [63:0]   data_next;
  logic [15:0]   err_next;
  logic [4:0]    corr_add;
  cw_result_t    lane_res;

  // Parity nibble of the code: p = d when d has even parity, otherwise ~d.
  function automatic logic [3:0] parity_of(input logic [3:0] d);
    return (^d) ? ~d : d;
  endfunction

  // Decode one codeword from its syndrome weight.
  function automatic cw_result_t decode_cw(input logic [7:0] cw);
    cw_result_t r;
    logic [3:0] s;
    s      = parity_of(cw[3:0]) ^ cw[7:4];
    r.nib  = cw[3:0];
    r.corr = 1'b0;
    r.unc  = 1'b0;
    case ($countones(s))
      0: ;
      1: r.corr = 1'b1;
      3: begin
        r.nib  = cw[3:0] ^ ~s;
        r.corr = 1'b1;
      end
      default: r.unc = 1'b1;
    endcase
    return r;
  endfunction

  assign busy      = (state != IDLE);
  assign valid_out = (state == DONE);

  // State register; reset aborts any decode in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic. DECODE stays one cycle past the final slot so the
  // last committed results are visible before DONE raises valid_out.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = DECODE;
      DECODE:  if (index == LAST_INDEX) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Decode the LANES codewords starting at index and merge them into the running results.
  always_comb begin
    data_next = data_out;
    err_next  = err_map;
    corr_add  = 5'd0;
    lane_res  = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_res = decode_cw(captured[((int'(index[3:0]) + l) & 15) * 8 +: 8]);
      data_next[((int'(index[3:0]) + l) & 15) * 4 +: 4] = lane_res.nib;
      err_next[(int'(index[3:0]) + l) & 15]           = lane_res.unc;
      corr_add = corr_add + 5'(lane_res.corr);
    end
  end

  // Capture on an accepted start, then commit one slot of lanes per DECODE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      captured        <= '0;
      index           <= '0;
      data_out        <= '0;
      corrected_count <= '0;
      uncorrectable   <= 1'b0;
      err_map         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            captured        <= Encoded_MEM_flat;
            index           <= '0;
            corrected_count <= '0;
            uncorrectable   <= 1'b0;
            err_map         <= '0;
          end
        end
        DECODE: begin
          if (index != LAST_INDEX) begin
            data_out        <= data_next;
            err_map         <= err_next;
            uncorrectable   <= |err_next;
            corrected_count <= corrected_count + corr_add;
            index           <= index + STEP;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_decoder.sv
// tb_ecc_decoder: directed vectors with hand-computed results for LANES=1 and LANES=4.
`timescale 1ns/1ps
module tb_ecc_decoder;

  localparam logic [127:0] CLEAN    = 128'h00E1D233B45566877899AA4BCC2D1EFF;
  localparam logic [127:0] ALL_01   = {16{8'h01}};
  localparam logic [63:0]  DATA_REF = 64'h0123456789ABCDEF;

  logic         clk;
  logic         reset;
  logic         start1;
  logic         start4;
  logic [127:0] flat;

  logic         busy1, valid1, unc1;
  logic [63:0]  data1;
  logic [4:0]   cc1;
  logic [15:0]  em1;

  logic         busy4, valid4, unc4;
  logic [63:0]  data4;
  logic [4:0]   cc4;
  logic [15:0]  em4;

  int test_count;
  int fail_count;
  int cycles;
  int stray_valid;

  ecc_decoder #(.LANES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .Encoded_MEM_flat(flat),
    .busy(busy1), .valid_out(valid1), .data_out(data1),
    .corrected_count(cc1), .uncorrectable(unc1), .err_map(em1)
  );

  ecc_decoder #(.LANES(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .Encoded_MEM_flat(flat),
    .busy(busy4), .valid_out(valid4), .data_out(data4),
    .corrected_count(cc4), .uncorrectable(unc4), .err_map(em4)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    test_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Pulse start on the chosen instance, optionally disturb the input afterwards,
  // and wait (bounded) for valid_out; returns edges counted after the start edge.
  task automatic applyStimulus(input logic [127:0] vec, input bit wide, input bit scramble, output int n);
    bit got;
    @(negedge clk);
    flat = vec;
    if (wide) start4 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start4 = 1'b0;
    if (scramble) flat = ~vec;
    n   = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (wide ? valid4 : valid1) got = 1'b1;
    end
    checkOutput("valid_seen", 128'(got), 128'd1);
  endtask

  initial begin
    test_count = 0;
    fail_count = 0;
    reset  = 1'b0;
    start1 = 1'b0;
    start4 = 1'b0;
    flat   = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 128'(busy1), 128'd0);
    checkOutput("rst_valid", 128'(valid1), 128'd0);
    checkOutput("rst_data", 128'(data1), 128'd0);
    checkOutput("rst_cc", 128'(cc1), 128'd0);
    checkOutput("rst_errmap", 128'(em1), 128'd0);
    reset = 1'b1;

    $display("[TB] clean decode, input disturbed during DECODE");
    applyStimulus(CLEAN, 1'b0, 1'b1, cycles);
    checkOutput("clean_latency", 128'(cycles), 128'd17);
    checkOutput("clean_busy_done", 128'(busy1), 128'd1);
    checkOutput("clean_data", 128'(data1), 128'(DATA_REF));
    checkOutput("clean_cc", 128'(cc1), 128'd0);
    checkOutput("clean_errmap", 128'(em1), 128'd0);
    checkOutput("clean_unc", 128'(unc1), 128'd0);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    checkOutput("post_done_busy", 128'(busy1), 128'd0);
    checkOutput("post_done_valid", 128'(valid1), 128'd0);
    checkOutput("held_data", 128'(data1), 128'(DATA_REF));
    @(negedge clk);
    checkOutput("done_start_ignored", 128'(busy1), 128'd0);

    $display("[TB] single data-bit error");
    applyStimulus(CLEAN ^ 128'h1, 1'b0, 1'b0, cycles);
    checkOutput("d1_data", 128'(data1), 128'(DATA_REF));
    checkOutput("d1_cc", 128'(cc1), 128'd1);
    checkOutput("d1_errmap", 128'(em1), 128'd0);

    $display("[TB] single parity-bit error");
    applyStimulus(CLEAN ^ (128'h1 << 127), 1'b0, 1'b0, cycles);
    checkOutput("p1_data", 128'(data1), 128'(DATA_REF));
    checkOutput("p1_cc", 128'(cc1), 128'd1);
    checkOutput("p1_unc", 128'(unc1), 128'd0);

    $display("[TB] double error in codeword 0");
    applyStimulus(CLEAN ^ 128'h3, 1'b0, 1'b0, cycles);
    checkOutput("dbl_errmap", 128'(em1), 128'h0001);
    checkOutput("dbl_unc", 128'(unc1), 128'd1);
    checkOutput("dbl_data", 128'(data1), 128'h0123456789ABCDEC);
    checkOutput("dbl_cc", 128'(cc1), 128'd0);

    $display("[TB] every codeword corrected");
    applyStimulus(ALL_01, 1'b0, 1'b0, cycles);
    checkOutput("sat_data", 128'(data1), 128'd0);
    checkOutput("sat_cc", 128'(cc1), 128'd16);
    checkOutput("sat_errmap", 128'(em1), 128'd0);
    applyStimulus(ALL_01, 1'b1, 1'b0, cycles);
    checkOutput("sat4_latency", 128'(cycles), 128'd5);
    checkOutput("sat4_data", 128'(data4), 128'd0);
    checkOutput("sat4_cc", 128'(cc4), 128'd16);
    checkOutput("sat4_unc", 128'(unc4), 128'd0);
    applyStimulus(CLEAN ^ 128'h3, 1'b1, 1'b0, cycles);
    checkOutput("dbl4_data", 128'(data4), 128'h0123456789ABCDEC);
    checkOutput("dbl4_errmap", 128'(em4), 128'h0001);

    $display("[TB] reset during decode");
    @(negedge clk);
    flat   = CLEAN;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    @(negedge clk);
    checkOutput("second_start_busy", 128'(busy1), 128'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("abort_busy", 128'(busy1), 128'd0);
    checkOutput("abort_valid", 128'(valid1), 128'd0);
    checkOutput("abort_data", 128'(data1), 128'd0);
    checkOutput("abort_cc", 128'(cc1), 128'd0);
    checkOutput("abort_errmap", 128'(em1), 128'd0);
    checkOutput("abort_unc", 128'(unc1), 128'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    stray_valid = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (valid1 || busy1) stray_valid++;
    end
    checkOutput("no_valid_after_abort", 128'(stray_valid), 128'd0);

    applyStimulus(CLEAN, 1'b0, 1'b0, cycles);
    checkOutput("restart_latency", 128'(cycles), 128'd17);
    checkOutput("restart_data", 128'(data1), 128'(DATA_REF));
    checkOutput("restart_cc", 128'(cc1), 128'd0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
